// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the uart_rx receiver.
package uart_rx_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PRESC_W    = 6;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - edge/bit counters and mid-bit sampling; UART_RX_MAJORITY_EN selects 2-of-3 voting.
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_active,
  input  logic               i_rx,
  input  logic [PRESC_W-1:0] i_prescale,
  output logic               o_sampled_bit,
  output logic               o_decide,
  output logic               o_bit_done,
  output logic [3:0]         o_bit_cnt
);

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] TWO = PRESC_W'(2);

  logic [PRESC_W-1:0] r_edge_cnt;
  logic [3:0]         r_bit_cnt;
  logic [PRESC_W-1:0] w_half;

  assign w_half     = i_prescale >> 1;
  assign o_bit_done = i_active && (r_edge_cnt == i_prescale - ONE);
  assign o_decide   = i_active && (r_edge_cnt == w_half + TWO);
  assign o_bit_cnt  = r_bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_start) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_active) begin
      if (o_bit_done) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + 4'd1;
      end else begin
        r_edge_cnt <= r_edge_cnt + ONE;
      end
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] r_samp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp <= 3'b111;
    end else if (i_active) begin
      if (r_edge_cnt == w_half - ONE) r_samp[0] <= i_rx;
      if (r_edge_cnt == w_half)       r_samp[1] <= i_rx;
      if (r_edge_cnt == w_half + ONE) r_samp[2] <= i_rx;
    end
  end

  assign o_sampled_bit = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) |
                         (r_samp[1] & r_samp[2]);
`else
  logic r_samp_mid;

  // Single mid-bit sample; decision still waits for edge Prescale/2+2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp_mid <= 1'b1;
    end else if (i_active && (r_edge_cnt == w_half)) begin
      r_samp_mid <= i_rx;
    end
  end

  assign o_sampled_bit = r_samp_mid;
`endif

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver top: frame FSM, deserialiser, parity/stop checks (UART_RX_MAJORITY_EN in sampler).
module uart_rx #(
  parameter int DATA_WIDTH = uart_rx_pkg::DATA_WIDTH,
  parameter int PRESC_W    = uart_rx_pkg::PRESC_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_TYP,
  input  logic                  PAR_EN,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);
  import uart_rx_pkg::*;

  state_t                r_state, w_next;
  logic [PRESC_W-1:0]    r_presc;
  logic                  r_par_en, r_par_typ;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_par_err, r_stop_err, r_data_valid;
  logic                  w_start, w_bit, w_decide, w_bit_done, w_par_exp;
  logic [3:0]            w_bit_cnt;

  assign w_start   = (r_state == IDLE) && !RX_IN;
  assign w_par_exp = (r_par_typ == ODD) ? ~^r_p_data : ^r_p_data;

  uart_rx_sampler u_sampler (
    .clk           (CLK),
    .rst_n         (RST),
    .i_start       (w_start),
    .i_active      (r_state != IDLE),
    .i_rx          (RX_IN),
    .i_prescale    (r_presc),
    .o_sampled_bit (w_bit),
    .o_decide      (w_decide),
    .o_bit_done    (w_bit_done),
    .o_bit_cnt     (w_bit_cnt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (!RX_IN) w_next = START;
      START: begin
        if (w_decide && w_bit) w_next = IDLE;
        else if (w_bit_done)   w_next = DATA;
      end
      DATA:   if (w_bit_done && w_bit_cnt == 4'(DATA_WIDTH)) w_next = r_par_en ? PARITY : STOP;
      PARITY: if (w_bit_done) w_next = STOP;
      STOP:   if (w_decide) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Frame configuration is frozen at start detection and flags restart clean.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_presc      <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_p_data     <= '0;
      r_par_err    <= 1'b0;
      r_stop_err   <= 1'b0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (w_start) begin
        r_presc    <= Prescale;
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_par_err  <= 1'b0;
        r_stop_err <= 1'b0;
      end
      if (r_state == DATA && w_decide) r_p_data <= {w_bit, r_p_data[DATA_WIDTH-1:1]};
      if (r_state == PARITY && w_decide && (w_bit != w_par_exp)) r_par_err <= 1'b1;
      if (r_state == STOP && w_decide) begin
        r_stop_err   <= !w_bit;
        r_data_valid <= w_bit && !r_par_err;
      end
    end
  end

  assign P_DATA       = r_p_data;
  assign data_valid   = r_data_valid;
  assign Parity_Error = r_par_err;
  assign Stop_Error   = r_stop_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_TYP;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       Parity_Error;
  logic       Stop_Error;

  int checks = 0;
  int failures = 0;
  int dv_cnt = 0;
  int perr_rise = 0;
  int serr_rise = 0;
  int dv_exp = 0;
  logic perr_q = 1'b0;
  logic serr_q = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_TYP      (PAR_TYP),
    .PAR_EN       (PAR_EN),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (data_valid === 1'b1) begin
        dv_cnt++;
        if (exp_q.size() == 0) check("dv_unexpected", exp_q.size(), 1);
        else check("p_data_at_valid", P_DATA, exp_q.pop_front());
      end
      if (Parity_Error === 1'b1 && !perr_q) perr_rise++;
      if (Stop_Error === 1'b1 && !serr_q) serr_rise++;
    end
    perr_q = (Parity_Error === 1'b1);
    serr_q = (Stop_Error === 1'b1);
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int presc, input logic pen,
                            input logic ptyp, input logic pbit, input logic stop,
                            input logic scramble);
    Prescale = 6'(presc);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    send_bit(1'b0, presc);
    if (scramble) begin
      Prescale = (presc == 8) ? 6'd32 : 6'd8;
      PAR_EN   = ~pen;
      PAR_TYP  = ~ptyp;
    end
    for (int i = 0; i < 8; i++) send_bit(d[i], presc);
    if (pen) send_bit(pbit, presc);
    send_bit(stop, presc);
    RX_IN    = 1'b1;
    Prescale = 6'(presc);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
  endtask

  initial begin
    int prs[3];
    prs[0] = 16; prs[1] = 8; prs[2] = 32;
    RX_IN = 1'b1; RST = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd16;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_p_data", P_DATA, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_perr", Parity_Error, 1'b0);
    check("rst_serr", Stop_Error, 1'b0);
    RST = 1'b1;
    idle(5);

    exp_q.push_back(8'hB2); dv_exp++;
    send_frame(8'hB2, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    check("nopar_p_data", P_DATA, 8'hB2);
    check("nopar_dv_cnt", dv_cnt, dv_exp);
    check("nopar_perr", Parity_Error, 1'b0);
    check("nopar_serr", Stop_Error, 1'b0);

    exp_q.push_back(8'hB2); dv_exp++;
    send_frame(8'hB2, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(8'hB2); dv_exp++;
    send_frame(8'hB2, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(20);
    check("par_ok_dv_cnt", dv_cnt, dv_exp);
    check("par_ok_perr_rise", perr_rise, 0);

    send_frame(8'hB2, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(20);
    check("par_bad_level", Parity_Error, 1'b1);
    check("par_bad_rise", perr_rise, 1);
    check("par_bad_no_dv", dv_cnt, dv_exp);

    send_frame(8'hB2, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(40);
    check("stop_bad_rise", serr_rise, 1);
    check("stop_bad_no_dv", dv_cnt, dv_exp);
    check("perr_cleared", Parity_Error, 1'b0);

    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(8'hB2); exp_q.push_back(8'hA4); dv_exp += 2;
      send_frame(8'hB2, prs[k], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(8'hA4, prs[k], 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(40);
      check("b2b_dv_cnt", dv_cnt, dv_exp);
      check("b2b_queue_empty", exp_q.size(), 0);
    end
    check("b2b_no_errs", perr_rise + serr_rise, 2);

    Prescale = 6'd8;
    PAR_EN = 1'b0;
    send_bit(1'b0, 3);
    idle(30);
    check("glitch_no_dv", dv_cnt, dv_exp);
    check("glitch_no_flags", perr_rise + serr_rise, 2);
    exp_q.push_back(8'h55); dv_exp++;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    check("after_glitch_dv", dv_cnt, dv_exp);
    check("after_glitch_data", P_DATA, 8'h55);

    exp_q.push_back(8'h3C); dv_exp++;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(30);
    check("cfg_change_dv", dv_cnt, dv_exp);
    check("cfg_change_perr", Parity_Error, 1'b0);

    Prescale = 6'd16;
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    RST = 1'b0;
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("midrst_p_data", P_DATA, 8'h00);
    check("midrst_flags", {Parity_Error, Stop_Error, data_valid}, 3'b000);
    RST = 1'b1;
    idle(60);
    check("midrst_no_dv", dv_cnt, dv_exp);
    exp_q.push_back(8'h81); dv_exp++;
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    check("final_dv", dv_cnt, dv_exp);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
